// File: rtl/decode_hazard_ctrl.sv
// Decode-stage control for the 5-stage MIPS pipeline: main decoder, load-use hazard
// detection, ID/EX control register with bubble insertion, and EX-stage ALU control.
module decode_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  output logic       branch,
  output logic       jump,
  output logic       jr,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       stall,
  output logic [1:0] ex_reg_dst,
  output logic       ex_alu_src,
  output logic [1:0] ex_mem_to_reg,
  output logic       ex_reg_write,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic [1:0] ex_alu_op,
  output logic [5:0] ex_funct,
  output logic [4:0] ex_rt,
  output logic [3:0] ex_alu_operation
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr = 6'h08;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  // Decoded control fields for the instruction currently in IF/ID.
  logic [1:0] dec_reg_dst;
  logic       dec_alu_src;
  logic [1:0] dec_mem_to_reg;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_jump;
  logic [1:0] dec_alu_op;

  always_comb begin
    dec_reg_dst    = 2'd0;
    dec_alu_src    = 1'b0;
    dec_mem_to_reg = 2'd0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_op     = 2'b00;
    case (opcode)
      OpRType: begin
        dec_reg_dst   = 2'd1;
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
      end
      OpLw: begin
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 2'd1;
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
      end
      OpSw: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OpBeq: begin
        dec_branch = 1'b1;
        dec_alu_op = 2'b01;
      end
      OpAddi: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OpJ: begin
        dec_jump = 1'b1;
      end
      OpJal: begin
        dec_reg_dst    = 2'd2;
        dec_mem_to_reg = 2'd2;
        dec_reg_write  = 1'b1;
        dec_jump       = 1'b1;
      end
      default: ;
    endcase
  end

  assign branch = dec_branch;
  assign jump   = dec_jump;
  assign jr     = (opcode == OpRType) && (funct == FnJr);

  // ID/EX register state.
  logic [1:0] reg_dst_q, reg_dst_d;
  logic       alu_src_q, alu_src_d;
  logic [1:0] mem_to_reg_q, mem_to_reg_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic [5:0] funct_q, funct_d;
  logic [4:0] rt_q, rt_d;

  // Load-use hazard: register 0 is hardwired, so a load targeting it never stalls.
  logic hazard;
  assign hazard = mem_read_q && (rt_q != 5'd0) &&
                  ((rt_q == if_id_rs) || (rt_q == if_id_rt));

  assign stall       = hazard;
  assign pc_write    = ~hazard;
  assign if_id_write = ~hazard;

  always_comb begin
    reg_dst_d    = dec_reg_dst;
    alu_src_d    = dec_alu_src;
    mem_to_reg_d = dec_mem_to_reg;
    reg_write_d  = dec_reg_write & ~jr;
    mem_read_d   = dec_mem_read;
    mem_write_d  = dec_mem_write;
    alu_op_d     = dec_alu_op;
    funct_d      = funct;
    rt_d         = if_id_rt;
    if (hazard) begin
      reg_dst_d    = 2'd0;
      alu_src_d    = 1'b0;
      mem_to_reg_d = 2'd0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      alu_op_d     = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_dst_q    <= 2'd0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 2'd0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_op_q     <= 2'b00;
      funct_q      <= 6'd0;
      rt_q         <= 5'd0;
    end else begin
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_op_q     <= alu_op_d;
      funct_q      <= funct_d;
      rt_q         <= rt_d;
    end
  end

  assign ex_reg_dst    = reg_dst_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_funct      = funct_q;
  assign ex_rt         = rt_q;

  // EX-stage ALU control; unlisted funct codes (shifts, jr) fall back to add.
  always_comb begin
    ex_alu_operation = AluAdd;
    unique case (alu_op_q)
      2'b00: ex_alu_operation = AluAdd;
      2'b01: ex_alu_operation = AluSub;
      2'b11: ex_alu_operation = AluAdd;
      2'b10: begin
        case (funct_q)
          6'h20, 6'h21: ex_alu_operation = AluAdd;
          6'h22, 6'h23: ex_alu_operation = AluSub;
          6'h24:        ex_alu_operation = AluAnd;
          6'h25:        ex_alu_operation = AluOr;
          6'h27:        ex_alu_operation = AluNor;
          6'h2A:        ex_alu_operation = AluSlt;
          default:      ex_alu_operation = AluAdd;
        endcase
      end
      default: ex_alu_operation = AluAdd;
    endcase
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: vector table with a scoreboard queue for the
// registered ID/EX fields, plus hand-written reset sequences.
module tb_decode_hazard_ctrl;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       branch, jump, jr, pc_write, if_id_write, stall;
  logic [1:0] ex_reg_dst;
  logic       ex_alu_src;
  logic [1:0] ex_mem_to_reg;
  logic       ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0] ex_alu_op;
  logic [5:0] ex_funct;
  logic [4:0] ex_rt;
  logic [3:0] ex_alu_operation;

  decode_hazard_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode           (opcode),
    .funct            (funct),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .branch           (branch),
    .jump             (jump),
    .jr               (jr),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .stall            (stall),
    .ex_reg_dst       (ex_reg_dst),
    .ex_alu_src       (ex_alu_src),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_alu_op        (ex_alu_op),
    .ex_funct         (ex_funct),
    .ex_rt            (ex_rt),
    .ex_alu_operation (ex_alu_operation)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       jmp;
    logic       jrx;
    logic       stl;
    logic [1:0] rd;
    logic       as;
    logic [1:0] m2r;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [1:0] aop;
    logic [3:0] aoper;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                              input logic [4:0] rt, input logic br, input logic jmp,
                              input logic jrx, input logic stl, input logic [1:0] rd,
                              input logic as, input logic [1:0] m2r, input logic rw,
                              input logic mr, input logic mw, input logic [1:0] aop,
                              input logic [3:0] aoper);
    vec_t v;
    v.op = op; v.fn = fn; v.rs = rs; v.rt = rt;
    v.br = br; v.jmp = jmp; v.jrx = jrx; v.stl = stl;
    v.rd = rd; v.as = as; v.m2r = m2r; v.rw = rw; v.mr = mr; v.mw = mw;
    v.aop = aop; v.aoper = aoper;
    return v;
  endfunction

  // Drive one instruction at negedge, check combinational outputs, then check ID/EX after edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    string t;
    @(negedge clk);
    opcode = v.op; funct = v.fn; if_id_rs = v.rs; if_id_rt = v.rt;
    sb.push_back(v);
    #1;
    t = $sformatf("v%0d", idx);
    chk({t, ".branch"}, 32'(branch), 32'(v.br));
    chk({t, ".jump"}, 32'(jump), 32'(v.jmp));
    chk({t, ".jr"}, 32'(jr), 32'(v.jrx));
    chk({t, ".stall"}, 32'(stall), 32'(v.stl));
    chk({t, ".pc_write"}, 32'(pc_write), 32'(!v.stl));
    chk({t, ".if_id_write"}, 32'(if_id_write), 32'(!v.stl));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({t, ".ex_reg_dst"}, 32'(ex_reg_dst), 32'(e.rd));
    chk({t, ".ex_alu_src"}, 32'(ex_alu_src), 32'(e.as));
    chk({t, ".ex_mem_to_reg"}, 32'(ex_mem_to_reg), 32'(e.m2r));
    chk({t, ".ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
    chk({t, ".ex_mem_read"}, 32'(ex_mem_read), 32'(e.mr));
    chk({t, ".ex_mem_write"}, 32'(ex_mem_write), 32'(e.mw));
    chk({t, ".ex_alu_op"}, 32'(ex_alu_op), 32'(e.aop));
    chk({t, ".ex_funct"}, 32'(ex_funct), 32'(e.fn));
    chk({t, ".ex_rt"}, 32'(ex_rt), 32'(e.rt));
    chk({t, ".ex_alu_operation"}, 32'(ex_alu_operation), 32'(e.aoper));
  endtask

  task automatic chk_reset_state(input string t);
    chk({t, ".ex_reg_dst"}, 32'(ex_reg_dst), 32'd0);
    chk({t, ".ex_alu_src"}, 32'(ex_alu_src), 32'd0);
    chk({t, ".ex_mem_to_reg"}, 32'(ex_mem_to_reg), 32'd0);
    chk({t, ".ex_reg_write"}, 32'(ex_reg_write), 32'd0);
    chk({t, ".ex_mem_read"}, 32'(ex_mem_read), 32'd0);
    chk({t, ".ex_mem_write"}, 32'(ex_mem_write), 32'd0);
    chk({t, ".ex_alu_op"}, 32'(ex_alu_op), 32'd0);
    chk({t, ".ex_funct"}, 32'(ex_funct), 32'd0);
    chk({t, ".ex_rt"}, 32'(ex_rt), 32'd0);
    chk({t, ".ex_alu_operation"}, 32'(ex_alu_operation), 32'b0010);
    chk({t, ".stall"}, 32'(stall), 32'd0);
    chk({t, ".pc_write"}, 32'(pc_write), 32'd1);
    chk({t, ".if_id_write"}, 32'(if_id_write), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    rst_n   = 1'b1;
    opcode  = 6'h00; funct = 6'h24; if_id_rs = 5'd5; if_id_rt = 5'd5;

    //         op     fn     rs  rt  br jmp jr stl rd as m2r rw mr mw aop    aoper
    vecs.push_back(mk(6'h00, 6'h24, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk(6'h00, 6'h2A, 3, 4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0111));
    vecs.push_back(mk(6'h00, 6'h25, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0001));
    vecs.push_back(mk(6'h00, 6'h27, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b1100));
    vecs.push_back(mk(6'h00, 6'h22, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0110));
    vecs.push_back(mk(6'h00, 6'h21, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0010));
    vecs.push_back(mk(6'h08, 6'h3F, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h2B, 6'h00, 6, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h04, 6'h00, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 4'b0110));
    vecs.push_back(mk(6'h02, 6'h00, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h03, 6'h00, 1, 2, 0, 1, 0, 0, 2, 0, 2, 1, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h00, 6'h08, 31, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 4'b0010));
    vecs.push_back(mk(6'h3F, 6'h24, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010));
    // lw rt=5, dependent on rs: one bubble, then normal issue
    vecs.push_back(mk(6'h23, 6'h00, 1, 5, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h00, 6'h20, 5, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h00, 6'h24, 5, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0000));
    // lw to r0 never stalls
    vecs.push_back(mk(6'h23, 6'h00, 2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h00, 6'h2A, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b0111));
    // lw rt=7, dependent on rt
    vecs.push_back(mk(6'h23, 6'h00, 1, 7, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h00, 6'h25, 2, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010));
    // lw then independent store
    vecs.push_back(mk(6'h23, 6'h00, 0, 8, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(6'h2B, 6'h00, 3, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 4'b0010));

    // Asynchronous reset with the clock idle.
    #2 rst_n = 1'b0;
    #1 chk_reset_state("reset");
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset arriving mid-stall cancels the stall without a clock edge.
    apply(mk(6'h23, 6'h00, 1, 5, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 4'b0010), 100);
    @(negedge clk);
    opcode = 6'h00; funct = 6'h20; if_id_rs = 5'd5; if_id_rt = 5'd1;
    #1 chk("midstall.stall_before", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_state("midstall");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(6'h00, 6'h27, 5, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b10, 4'b1100), 101);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_hazard_ctrl.md
# decode_hazard_ctrl

Decode-stage control block for the 5-stage MIPS pipeline. Combines the main opcode decoder, the ID/EX control-bundle register with bubble insertion, ALU operation decoding for the EX stage, and load-use hazard detection. It sits between the IF/ID register and the EX-stage datapath.

## Interface
- Parameters: none.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IF/ID instruction[31:26]
- funct  in  6  IF/ID instruction[5:0]
- if_id_rs  in  5  IF/ID instruction[25:21]
- if_id_rt  in  5  IF/ID instruction[20:16]
- branch  out  1  combinational; beq decoded
- jump  out  1  combinational; j or jal decoded
- jr  out  1  combinational; opcode 0x00 and funct 0x08
- pc_write  out  1  combinational; 0 during load-use stall
- if_id_write  out  1  combinational; 0 during load-use stall
- stall  out  1  combinational; 1 during load-use stall
- ex_reg_dst  out  2  registered; 0 = rt, 1 = rd, 2 = register 31
- ex_alu_src  out  1  registered; 1 = sign-extended immediate
- ex_mem_to_reg  out  2  registered; 0 = ALU result, 1 = memory data, 2 = PC+4
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered
- ex_alu_op  out  2  registered ALU op class
- ex_funct  out  6  registered funct
- ex_rt  out  5  registered if_id_rt
- ex_alu_operation  out  4  combinational, from ex_alu_op and ex_funct

## Operation
- Main decode (combinational). Fields are listed as reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op:
  - 0x00 R-type: 1,0,0,1,0,0,0,0,10
  - 0x23 lw: 0,1,1,1,1,0,0,0,00
  - 0x2B sw: 0,1,0,0,0,1,0,0,00
  - 0x04 beq: 0,0,0,0,0,0,1,0,01
  - 0x08 addi: 0,1,0,1,0,0,0,0,00
  - 0x02 j: all zero except jump=1
  - 0x03 jal: reg_dst=2, mem_to_reg=2, reg_write=1, jump=1, others 0
  - any other opcode: all zero
- Hazard detection:
  - stall = ex_mem_read AND ex_rt != 0 AND (ex_rt == if_id_rs OR ex_rt == if_id_rt).
  - pc_write = if_id_write = NOT stall.
- ID/EX register, updated every rising clk:
  - If stall is high, load zeros into all control fields (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op). This inserts a bubble.
  - Otherwise, load the decoded control fields.
  - ex_reg_write is also forced to 0 when jr is high.
  - ex_funct and ex_rt always load funct and if_id_rt, including during a stall.
- ALU control (combinational):
  - ex_alu_op 00 → 0010 (add).
  - ex_alu_op 01 → 0110 (sub).
  - ex_alu_op 11 → 0010.
  - ex_alu_op 10 decodes ex_funct: 0x20/0x21 → 0010, 0x22/0x23 → 0110, 0x24 → 0000 (and), 0x25 → 0001 (or), 0x27 → 1100 (nor), 0x2A → 0111 (slt). Any other funct, including 0x00 and 0x08, → 0010.

## Timing
- Decode, hazard and ALU-control outputs are purely combinational, with zero latency.
- The ID/EX fields have one cycle of latency: inputs sampled at edge N appear after edge N.
- A load followed immediately by a dependent instruction stalls for exactly one cycle. After the edge that loads the bubble, ex_mem_read = 0, so stall deasserts.
- Reset (rst_n low, asynchronous) clears every registered field to 0 immediately. As a result, ex_alu_operation = 0010, stall = 0, and pc_write = if_id_write = 1. Reset release is synchronous to the next rising clk.
- Reset mid-stall cancels the stall immediately.
- The comparison ex_rt == 0 never stalls.

## Test plan
- Reset: assert rst_n=0 with clk idle → all ex_* = 0, ex_alu_operation = 0010, pc_write = 1.
- R-type and: opcode 0x00, funct 0x24, one edge → ex_reg_dst = 1, ex_reg_write = 1, ex_alu_op = 10, ex_alu_operation = 0000. Repeat with funct 0x2A → 0111.
- lw then dependent: clock in lw with rt = 5 (ex_mem_read = 1, ex_rt = 5), then present if_id_rs = 5 → stall = 1, pc_write = 0, if_id_write = 0. After the next edge, all ex_* control = 0 and stall = 0.
- lw with rt = 0 followed by if_id_rs = 0 → stall = 0.
- jal: opcode 0x03 → jump = 1; after one edge, ex_reg_dst = 2, ex_mem_to_reg = 2, ex_reg_write = 1.
- jr: opcode 0x00, funct 0x08 → jr = 1; after one edge, ex_reg_write = 0.
- beq: opcode 0x04 → branch = 1; after one edge, ex_alu_operation = 0110.
- Unknown opcode 0x3F → all control outputs 0.
